// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// holds one instruction in the IF/ID slot, with stall, redirect and flush.
module fetch_unit #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_DROP
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_addr;
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   r_pend_pc;
    logic [XLEN-1:0]   r_pend_instr;
    logic [XLEN-1:0]   r_target;

    state_t            w_state_nxt;
    logic [XLEN-1:0]   w_addr_nxt;
    logic              w_valid_nxt;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_instr_nxt;
    logic [XLEN-1:0]   w_pend_pc_nxt;
    logic [XLEN-1:0]   w_pend_instr_nxt;
    logic [XLEN-1:0]   w_target_nxt;

    logic              w_drain;
    logic [XLEN-1:0]   w_addr_inc;
    logic [XLEN-1:0]   w_redir_tgt;

    assign w_drain     = r_valid & ~stall;
    assign w_addr_inc  = r_addr + XLEN'(4);
    assign w_redir_tgt = redirect_pc & ~XLEN'(3);

    assign imem_req  = (r_state == S_FETCH) || (r_state == S_DROP);
    assign imem_addr = r_addr;
    assign if_valid  = r_valid;
    assign if_pc     = r_pc;
    assign if_instr  = r_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BOOT;
            r_addr       <= RESET_PC;
            r_valid      <= 1'b0;
            r_pc         <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_pend_pc    <= '0;
            r_pend_instr <= '0;
            r_target     <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_valid      <= w_valid_nxt;
            r_pc         <= w_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_pend_instr <= w_pend_instr_nxt;
            r_target     <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_valid_nxt      = r_valid;
        w_pc_nxt         = r_pc;
        w_instr_nxt      = r_instr;
        w_pend_pc_nxt    = r_pend_pc;
        w_pend_instr_nxt = r_pend_instr;
        w_target_nxt     = r_target;

        // A consumed slot empties unless something below refills it.
        if (w_drain) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
        end

        unique case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
                if (redirect) begin
                    w_addr_nxt = w_redir_tgt;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        w_addr_nxt = w_redir_tgt;
                    end else begin
                        w_target_nxt = w_redir_tgt;
                        w_state_nxt  = S_DROP;
                    end
                end else if (imem_ack) begin
                    w_addr_nxt = w_addr_inc;
                    if (!r_valid || w_drain) begin
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = r_addr;
                        w_instr_nxt = imem_rdata;
                    end else begin
                        w_pend_pc_nxt    = r_addr;
                        w_pend_instr_nxt = imem_rdata;
                        w_state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_addr_nxt  = w_redir_tgt;
                    w_state_nxt = S_FETCH;
                end else if (w_drain) begin
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pend_pc;
                    w_instr_nxt = r_pend_instr;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_target_nxt = w_redir_tgt;
                end
                // The in-flight word is discarded; a same-cycle redirect wins.
                if (imem_ack) begin
                    w_addr_nxt  = redirect ? w_redir_tgt : r_target;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase

        if (redirect) begin
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_INSTR;
        end
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        r_addr[1:0] == 2'b00);
    a_empty_is_nop: assert property (@(posedge clk) disable iff (!rst_n)
        !r_valid |-> (r_instr == NOP_INSTR));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory latency, stall and redirect
// against a program-order PC stream model, plus directed boot/hold/wrap/reset.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [31:0] model_pc = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_consumed = 0;
    int          idle = 0;
    logic        have_prev = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Expected stream: sequential words from the last redirect target.
    function automatic void refill();
        while (sb_q.size() < 8) begin
            sb_q.push_back('{pc: model_pc, instr: memf(model_pc)});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    task automatic drive(input logic rd, input logic [31:0] tgt, input logic st,
                         input int unsigned pct);
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        imem_ack    = imem_req && ($urandom_range(99) < pct);
        imem_rdata  = memf(imem_addr);
        if (rd) begin
            sb_q.delete();
            model_pc = tgt & 32'hFFFF_FFFC;
        end
        refill();
    endtask

    task automatic step(input logic rd, input logic [31:0] tgt, input logic st,
                        input int unsigned pct);
        @(posedge clk);
        #1;
        drive(rd, tgt, st, pct);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            have_prev = 1'b0;
            idle      = 0;
        end else begin
            if (have_prev && prev_req && !prev_ack && imem_req)
                chk("addr_hold", imem_addr, prev_addr);
            if (!if_valid)
                chk("nop_when_empty", if_instr, NOP);
            if (if_valid && !stall && !redirect) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL slot_unexpected: got pc %h expected none", if_pc);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("slot_pc", if_pc, sb_e.pc);
                    chk("slot_instr", if_instr, sb_e.instr);
                    n_consumed++;
                end
                idle = 0;
            end else begin
                idle++;
                if (idle == 300) begin
                    n_checks++;
                    $display("FAIL progress_timeout: got %0d idle cycles required < 300", idle);
                    idle = 0;
                end
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
            have_prev = 1'b1;
        end
    end

    initial begin
        logic        rd;
        logic        st;
        logic [31:0] t;
        int unsigned w;

        drive(1'b0, '0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP);

        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 100);
        chk("boot_req_low", {31'd0, imem_req}, 32'd0);

        step(1'b0, '0, 1'b0, 100);
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        chk("boot_addr0", imem_addr, 32'h0);
        step(1'b0, '0, 1'b0, 100);
        chk("boot_addr4", imem_addr, 32'h4);
        chk("boot_pc0", if_pc, 32'h0);
        step(1'b0, '0, 1'b0, 100);
        chk("boot_addr8", imem_addr, 32'h8);
        chk("boot_pc4", if_pc, 32'h4);

        step(1'b0, '0, 1'b1, 100);
        chk("stall_pc8", if_pc, 32'h8);
        chk("stall_addrC", imem_addr, 32'hC);
        repeat (3) begin
            step(1'b0, '0, 1'b1, 100);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            chk("hold_pc", if_pc, 32'h8);
        end
        step(1'b0, '0, 1'b0, 100);
        chk("hold_release_pc", if_pc, 32'h8);
        step(1'b0, '0, 1'b0, 0);
        chk("resume_pc", if_pc, 32'hC);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h10);

        drive(1'b1, 32'h0000_0102, 1'b0, 0);
        step(1'b0, '0, 1'b0, 0);
        chk("drop_flush_valid", {31'd0, if_valid}, 32'd0);
        chk("drop_flush_instr", if_instr, NOP);
        chk("drop_addr_held", imem_addr, 32'h10);
        step(1'b0, '0, 1'b0, 100);
        chk("drop_addr_held2", imem_addr, 32'h10);
        step(1'b0, '0, 1'b0, 100);
        chk("drop_target", imem_addr, 32'h100);
        chk("drop_valid", {31'd0, if_valid}, 32'd0);
        step(1'b0, '0, 1'b0, 100);
        chk("target_pc", if_pc, 32'h100);

        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 100);
        step(1'b0, '0, 1'b0, 100);
        chk("redir_prio_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_prio_addr", imem_addr, 32'hFFFF_FFFC);
        step(1'b0, '0, 1'b0, 100);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(99) < 4);
            st = ($urandom_range(99) < 30);
            if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else t = $urandom;
            step(rd, t, st, $urandom_range(20, 100));
        end

        w = 0;
        step(1'b0, '0, 1'b0, 0);
        while (!imem_req && w < 20) begin
            step(1'b0, '0, 1'b0, 0);
            w++;
        end
        chk("pre_drop_req", {31'd0, imem_req}, 32'd1);
        drive(1'b1, 32'h0000_0040, 1'b0, 0);
        step(1'b0, '0, 1'b0, 0);
        chk("in_drop_req", {31'd0, imem_req}, 32'd1);
        #3;
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 0);
        sb_q.delete();
        model_pc = 32'h0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_valid", {31'd0, if_valid}, 32'd0);
        chk("async_pc", if_pc, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_instr", if_instr, NOP);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h0000_0200, 1'b0, 100);
        step(1'b0, '0, 1'b0, 100);
        chk("boot_redir_addr", imem_addr, 32'h200);
        chk("boot_redir_req", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 60; i++) begin
            st = ($urandom_range(99) < 30);
            step(1'b0, '0, st, $urandom_range(20, 100));
        end
        step(1'b0, '0, 1'b0, 0);
        @(negedge clk);

        chk("enough_consumed", {31'd0, n_consumed >= 500}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
